layer_0_input_packer: RTL

Upstream feeder for layer_0_featuremap_* instances. Accepts an 8-bit RGB pixel stream with a valid/ready handshake and converts each channel to IEEE-754 float32 scaled by 1/256. Packs the three channels into the 96-bit word that drives data_in/valid_in of every layer-0 feature-map block. Frames a raster of IMG_SIZE x IMG_SIZE pixels and reports frame completion.

---
 rtl/layer_0_pkg.sv | 23 ++
 rtl/u8_to_fp32.sv | 29 ++
 rtl/layer_0_input_packer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/layer_0_pkg.sv
// Shared constants, FSM state type and pixel payload layout for the layer-0 input packer.
package layer_0_pkg;

    localparam int unsigned PIX_W         = 8;
    localparam int unsigned FP32_W        = 32;
    localparam int unsigned FP32_EXP_BIAS = 127;
    localparam int unsigned NORM_SHIFT    = 8;
    localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // One RGB pixel as it arrives on s_data: B in the top byte, R in the bottom byte.
    typedef struct packed {
        logic [PIX_W-1:0] b;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] r;
    } pix_t;

endpackage

// File: rtl/u8_to_fp32.sv
// Exact conversion of an unsigned 8-bit sample to float32 v/256 (combinational).
module u8_to_fp32
    import layer_0_pkg::*;
(
    input  logic [PIX_W-1:0]  v,
    output logic [FP32_W-1:0] f_c
);

    localparam int unsigned MSB_W = $clog2(PIX_W);

    logic [MSB_W-1:0] msb;
    logic [7:0]       exp_c;
    logic [22:0]      man_c;

    always_comb begin
        msb = '0;
        for (int i = 0; i < int'(PIX_W); i++) begin
            if (v[i]) begin
                msb = MSB_W'(i);
            end
        end
        // Scaling by 1/256 folds into the biased exponent.
        exp_c = 8'(FP32_EXP_BIAS - NORM_SHIFT) + 8'(msb);
        // Shifting the leading one out past bit 22 leaves the fraction left-aligned.
        man_c = 23'(v) << (5'd23 - 5'(msb));
        f_c   = (v == '0) ? FP32_ZERO : {1'b0, exp_c, man_c};
    end

endmodule

// File: rtl/layer_0_input_packer.sv
// RGB u8 pixel stream to packed 3 x float32 words for the layer-0 feature maps, framed per raster.
// Optional zero border via LAYER0_ZERO_PAD_EN.
module layer_0_input_packer
    import layer_0_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DATA_IN_WIDTH = 96,
    parameter int unsigned IMG_SIZE      = 416
)(
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    input  logic [3*PIX_W-1:0]       s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [DATA_IN_WIDTH-1:0] data_out,
    output logic                     valid_out,
    output logic                     busy,
    output logic                     frame_done
);

`ifdef LAYER0_ZERO_PAD_EN
    localparam int unsigned RASTER = IMG_SIZE + 2;
`else
    localparam int unsigned RASTER = IMG_SIZE;
`endif
    localparam int unsigned CNT_W = $clog2(IMG_SIZE + 2);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(RASTER - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         col_q, col_d;
    logic [CNT_W-1:0]         row_q, row_d;
    logic                     s_ready_q, s_ready_d;
    logic                     s1_valid_q, s1_valid_d;
    pix_t                     s1_pix_q, s1_pix_d;
    logic                     valid_out_q, valid_out_d;
    logic [DATA_IN_WIDTH-1:0] data_out_q, data_out_d;
    logic                     frame_done_q, frame_done_d;
    logic                     busy_q, busy_d;
    logic                     load;
    logic                     inject;

    logic [DATA_WIDTH-1:0]    fp_r, fp_g, fp_b;

    u8_to_fp32 u_cvt_r (.v(s1_pix_q.r), .f_c(fp_r));
    u8_to_fp32 u_cvt_g (.v(s1_pix_q.g), .f_c(fp_g));
    u8_to_fp32 u_cvt_b (.v(s1_pix_q.b), .f_c(fp_b));

    // Next-state, raster walk and both pipeline stages.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        s1_valid_d   = 1'b0;
        s1_pix_d     = s1_pix_q;
        valid_out_d  = s1_valid_q;
        data_out_d   = data_out_q;
        frame_done_d = 1'b0;
        load         = 1'b0;
        inject       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
`ifdef LAYER0_ZERO_PAD_EN
                // s_ready_q is low exactly on border positions while streaming.
                if (s_ready_q) begin
                    load = s_valid;
                end else begin
                    load   = 1'b1;
                    inject = 1'b1;
                end
`else
                load = s_valid && s_ready_q;
`endif
                if (load) begin
                    s1_valid_d = 1'b1;
                    s1_pix_d   = inject ? '0 : pix_t'(s_data);
                    if (col_q == LAST_POS) begin
                        col_d = '0;
                        if (row_q == LAST_POS) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + CNT_W'(1);
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (s1_valid_q) begin
                    frame_done_d = 1'b1;
                end
                if (frame_done_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (s1_valid_q) begin
            data_out_d = {fp_b, fp_g, fp_r};
        end

        busy_d = (state_d != IDLE);
`ifdef LAYER0_ZERO_PAD_EN
        s_ready_d = (state_d == STREAM) &&
                    (col_d != '0) && (col_d != LAST_POS) &&
                    (row_d != '0) && (row_d != LAST_POS);
`else
        s_ready_d = (state_d == STREAM);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            s_ready_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= '0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            s_ready_q    <= s_ready_d;
            s1_valid_q   <= s1_valid_d;
            s1_pix_q     <= s1_pix_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
